mac_lane: RTL and testbench
===========================

Name: mac_lane

Overview:
- Single-lane, 2-stage pipelined multiply-accumulate: y = a*b + c, with signed/unsigned operand selection and a per-lane mask bypass.
- Instantiated once per lane inside the vector MAC array.
- valid/ready streaming handshake on both input and output sides.

Parameters:
- EW, 16, element width of multiplicands a and b (bits).
- AW, 32, accumulator/addend/result width (bits); must be >= EW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; state is cleared on a rising clk edge while rst=0.
- in_valid  in  1  input beat valid.
- in_ready  out  1  lane can accept an input beat this cycle.
- a  in  EW  multiplicand.
- b  in  EW  multiplier.
- c  in  AW  addend.
- lane_mask  in  1  1 = lane disabled; result is c unchanged.
- op_signed  in  1  1 = a, b, c are two's complement; 0 = unsigned.
- out_valid  out  1  y holds a valid result.
- out_ready  in  1  downstream accepts y.
- y  out  AW  result.

Behaviour:
- Reset (rst=0 at clk edge):
  - stage-1 valid, out_valid and y all cleared to 0; all pipeline data registers cleared.
  - in_ready is 0 while rst=0; inputs are ignored.
- Advance enable: adv = ~out_valid | out_ready.
  - in_ready = rst & adv (combinational).
  - The whole pipeline moves together when adv=1 and holds all registers when adv=0.
- Input acceptance: a beat is accepted when in_valid & in_ready.
- Stage 1 (registered when adv=1):
  - s1_valid <= in_valid.
  - s1_prod <= a*b computed at 2*EW bits; signed multiply when op_signed=1, unsigned otherwise.
  - c, lane_mask and op_signed are registered alongside.
- Stage 2 (registered when adv=1):
  - out_valid <= s1_valid.
  - y <= s1_mask ? s1_c : ext(s1_prod) + s1_c.
  - When s1_valid=0, y keeps its previous value.
- Width rule for ext():
  - sign-extend (op_signed=1) or zero-extend (op_signed=0) s1_prod to AW.
  - if 2*EW > AW, truncate to the low AW bits.
  - The sum is modulo 2^AW (wrap) unless SATURATE_EN is defined.
- Latency: exactly 2 rising edges from acceptance to y/out_valid, with no stall. Throughput: 1 beat/cycle while out_ready=1.
- Back-pressure:
  - out_valid=1 & out_ready=0 holds y, out_valid and stage 1 stable, and in_ready=0.
  - No beat is dropped or duplicated.
- Mask: result = c exactly, with the same latency and out_valid behaviour as an unmasked beat. op_signed is ignored and no saturation is applied.
- Mode switching: lane_mask and op_signed may change on every beat; each beat uses the values captured with it.
- Reset mid-operation: all in-flight beats are discarded; out_valid=0 on the cycle after the reset edge.

Optional Feature:
- Macro: MAC_LANE_SATURATE_EN.
- Defined: the stage-2 addition saturates instead of wrapping.
  - Signed mode: overflow clamps to 2^(AW-1)-1 and underflow clamps to -2^(AW-1).
  - Unsigned mode: carry-out clamps to 2^AW-1.
  - Masked beats are unaffected.
- Not defined: wrap-around modulo 2^AW, no extra logic.

Test Plan:
- Unsigned, lane_mask=0, out_ready=1: a=3, b=4, c=5 held 2 cycles -> y=17. a=10, b=10, c=0 -> y=100. a=255, b=2, c=1 -> y=511.
- Signed, op_signed=1: a=-3 (0xFFFD), b=4, c=10 -> y=-2 (0xFFFFFFFE). a=-5, b=-5, c=0 -> y=25.
- Mask: lane_mask=1, a=12, b=3, c=50 -> y=50, out_valid=1 two edges after acceptance.
- Streaming and back-pressure: 4 back-to-back beats, then out_ready=0 for 3 cycles -> y and out_valid held, in_ready=0. Release -> results appear in order, none lost or duplicated.
- Wrap/saturate, unsigned: a=0xFFFF, b=0xFFFF, c=0xFFFFFFFF.
  - Without the macro -> y=0xFFFE0000.
  - With MAC_LANE_SATURATE_EN -> y=0xFFFFFFFF.
- Reset: assert rst=0 with a beat in flight -> next cycle out_valid=0 and y=0; after rst=1, first accepted beat appears 2 cycles later.

Source files
------------

// File: rtl/mac_lane.sv
// ----------------------------------------------------------------------------
// mac_lane
//
// Purpose:
//   One lane of the vector MAC array. Computes y = a*b + c in a 2-stage
//   pipeline. Operands can be treated as signed or unsigned per beat, and a
//   per-beat lane mask bypasses the arithmetic so the result is c unchanged.
//   Both sides use a valid/ready streaming handshake, and the whole pipeline
//   advances together whenever the output register is free or being drained.
//
// Configuration macro:
//   MAC_LANE_SATURATE_EN - when defined, the stage-2 addition saturates
//                          (signed: clamp to +max / -min, unsigned: clamp to
//                          all-ones) instead of wrapping modulo 2^AW.
//
// Parameters:
//   EW - width of multiplicands a and b
//   AW - width of addend c and result y (must be >= EW)
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  lane can accept an input beat this cycle
//   a, b       in   multiplicand / multiplier (EW bits)
//   c          in   addend (AW bits)
//   lane_mask  in   1 = lane disabled, result is c unchanged
//   op_signed  in   1 = a, b, c are two's complement
//   out_valid  out  y holds a valid result
//   out_ready  in   downstream accepts y
//   y          out  result (AW bits)
// ----------------------------------------------------------------------------
module mac_lane #(
    parameter int EW = 16,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] a,
    input  logic [EW-1:0] b,
    input  logic [AW-1:0] c,
    input  logic          lane_mask,
    input  logic          op_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] y
);

    localparam int PW = 2 * EW;

    logic          adv;
    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] mul_prod;
    logic [AW-1:0] prod_ext;

    logic          s1_valid;
    logic [AW-1:0] s1_prod;
    logic [AW-1:0] s1_c;
    logic          s1_mask;
`ifdef MAC_LANE_SATURATE_EN
    logic          s1_signed;
`endif

    logic [AW-1:0] sum_res;
    logic [AW-1:0] y_next;

    // The pipeline only moves when the output register is empty or is being
    // consumed this cycle; otherwise every register holds. Holding reset low
    // also closes the input side.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = rst & adv;

    // A single multiplier serves both modes: operands are widened to the full
    // product width (sign- or zero-extended), and the low PW bits of that
    // product are the correct two's complement or unsigned result.
    always_comb begin
        a_ext    = op_signed ? {{EW{a[EW-1]}}, a} : {{EW{1'b0}}, a};
        b_ext    = op_signed ? {{EW{b[EW-1]}}, b} : {{EW{1'b0}}, b};
        mul_prod = a_ext * b_ext;
    end

    // The product is widened (or truncated) to the accumulator width before
    // it is registered, so stage 1 holds it already in the form stage 2 adds.
    generate
        if (AW > PW) begin : g_prod_extend
            assign prod_ext = {{(AW-PW){op_signed & mul_prod[PW-1]}}, mul_prod};
        end else begin : g_prod_trunc
            assign prod_ext = mul_prod[AW-1:0];
        end
    endgenerate

`ifdef MAC_LANE_SATURATE_EN
    // Saturating add: a signed overflow shows up as two same-signed operands
    // producing a result of the other sign; an unsigned overflow is the
    // carry out of the top bit.
    logic [AW:0] sum_full;

    always_comb begin
        sum_full = {1'b0, s1_prod} + {1'b0, s1_c};
        sum_res  = sum_full[AW-1:0];
        if (s1_signed) begin
            if ((s1_prod[AW-1] == s1_c[AW-1]) && (sum_full[AW-1] != s1_prod[AW-1])) begin
                sum_res = s1_prod[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            end
        end else if (sum_full[AW]) begin
            sum_res = '1;
        end
    end
`else
    // Plain modulo-2^AW add; sign does not matter for a wrapping sum.
    assign sum_res = s1_prod + s1_c;
`endif

    // A masked beat forwards its addend untouched, skipping both the product
    // and any saturation.
    assign y_next = s1_mask ? s1_c : sum_res;

    // Both pipeline stages live in one register block so they always advance
    // or stall together. y is only overwritten by a valid beat, so a bubble
    // leaves the last result visible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            s1_c      <= '0;
            s1_mask   <= 1'b0;
`ifdef MAC_LANE_SATURATE_EN
            s1_signed <= 1'b0;
`endif
            out_valid <= 1'b0;
            y         <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_prod   <= prod_ext;
            s1_c      <= c;
            s1_mask   <= lane_mask;
`ifdef MAC_LANE_SATURATE_EN
            s1_signed <= op_signed;
`endif
            out_valid <= s1_valid;
            if (s1_valid) begin
                y <= y_next;
            end
        end
    end

endmodule

// File: tb/tb_mac_lane.sv
// ----------------------------------------------------------------------------
// tb_mac_lane
//
// Directed bench for mac_lane (EW=16, AW=32). Each scenario task drives its
// own beats and compares the lane outputs against hand-computed results.
// Expected wrap/saturate results follow MAC_LANE_SATURATE_EN.
// ----------------------------------------------------------------------------
module tb_mac_lane;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] c;
    logic        lane_mask;
    logic        op_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;

    int checks;
    int failures;

    mac_lane #(
        .EW(16),
        .AW(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .lane_mask (lane_mask),
        .op_signed (op_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a stuck run still ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] timeout");
    end

    // Drives one beat for a single cycle; returns at the falling edge just
    // after the accepting rising edge.
    task automatic apply_stimulus(input logic [15:0] ta, input logic [15:0] tb,
                                  input logic [31:0] tc, input logic tm,
                                  input logic ts);
        @(negedge clk);
        a         = ta;
        b         = tb;
        c         = tc;
        lane_mask = tm;
        op_signed = ts;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Reset clears the outputs, closes the input side and ignores a beat
    // presented while it is held.
    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a = 16'd9; b = 16'd9; c = 32'd9; lane_mask = 1'b0; op_signed = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (y !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_y: got %h expected 00000000", y);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_no_ghost_beat: got out_valid=%b expected 0", out_valid);
        end
    endtask

    // Unsigned multiply-add, including exact two-edge latency.
    task automatic test_unsigned();
        logic [15:0] va[3]  = '{16'd3, 16'd10, 16'd255};
        logic [15:0] vb[3]  = '{16'd4, 16'd10, 16'd2};
        logic [31:0] vc[3]  = '{32'd5, 32'd0, 32'd1};
        logic [31:0] ve[3]  = '{32'd17, 32'd100, 32'd511};
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(va[i], vb[i], vc[i], 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL unsigned_latency[%0d]: out_valid=%b after one edge, expected 0", i, out_valid);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || y !== ve[i]) begin
                failures++;
                $display("[TB] FAIL unsigned_result[%0d]: got valid=%b y=%h expected valid=1 y=%h",
                         i, out_valid, y, ve[i]);
            end
        end
    endtask

    // Two's complement operands.
    task automatic test_signed();
        logic [15:0] va[2]  = '{16'hFFFD, 16'hFFFB};
        logic [15:0] vb[2]  = '{16'd4, 16'hFFFB};
        logic [31:0] vc[2]  = '{32'd10, 32'd0};
        logic [31:0] ve[2]  = '{32'hFFFFFFFE, 32'd25};
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(va[i], vb[i], vc[i], 1'b0, 1'b1);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL signed_latency[%0d]: out_valid=%b after one edge, expected 0", i, out_valid);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || y !== ve[i]) begin
                failures++;
                $display("[TB] FAIL signed_result[%0d]: got valid=%b y=%h expected valid=1 y=%h",
                         i, out_valid, y, ve[i]);
            end
        end
    endtask

    // A masked beat returns c with the normal latency.
    task automatic test_mask();
        apply_stimulus(16'd12, 16'd3, 32'd50, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mask_latency: out_valid=%b after one edge, expected 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || y !== 32'd50) begin
            failures++;
            $display("[TB] FAIL mask_result: got valid=%b y=%h expected valid=1 y=00000032", out_valid, y);
        end
    endtask

    // Overflowing unsigned sum: wraps by default, clamps with saturation.
    task automatic test_wrap();
        logic [31:0] exp_y;
`ifdef MAC_LANE_SATURATE_EN
        exp_y = 32'hFFFFFFFF;
`else
        exp_y = 32'hFFFE0000;
`endif
        apply_stimulus(16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || y !== exp_y) begin
            failures++;
            $display("[TB] FAIL wrap_unsigned: got valid=%b y=%h expected valid=1 y=%h", out_valid, y, exp_y);
        end
        // Masked beat with the same overflowing operands is never clamped.
        apply_stimulus(16'hFFFF, 16'hFFFF, 32'h7FFFFFFF, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || y !== 32'h7FFFFFFF) begin
            failures++;
            $display("[TB] FAIL wrap_masked: got valid=%b y=%h expected valid=1 y=7fffffff", out_valid, y);
        end
    endtask

    // Four back-to-back beats with mixed modes, then a 3-cycle stall; every
    // result must come out once, in order.
    task automatic test_back_to_back();
        logic [15:0] va[4]  = '{16'd1, 16'd4, 16'd7, 16'hFFFE};
        logic [15:0] vb[4]  = '{16'd2, 16'd5, 16'd8, 16'd3};
        logic [31:0] vc[4]  = '{32'd3, 32'd6, 32'd9, 32'd0};
        logic        vm[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        vs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] ve[4]  = '{32'd5, 32'd6, 32'd65, 32'hFFFFFFFA};
        int got = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k < 4) begin
                a         = va[k];
                b         = vb[k];
                c         = vc[k];
                lane_mask = vm[k];
                op_signed = vs[k];
                in_valid  = 1'b1;
            end else begin
                in_valid  = 1'b0;
            end
            out_ready = (k >= 4 && k <= 6) ? 1'b0 : 1'b1;
            #1;
            if (k < 4) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL b2b_in_ready[%0d]: got %b expected 1", k, in_ready);
                end
            end
            if (k >= 4 && k <= 6) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== ve[2]) begin
                    failures++;
                    $display("[TB] FAIL b2b_stall[%0d]: got in_ready=%b valid=%b y=%h expected 0 1 %h",
                             k, in_ready, out_valid, y, ve[2]);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (got >= 4) begin
                    failures++;
                    $display("[TB] FAIL b2b_extra: unexpected result y=%h, expected none", y);
                end else begin
                    if (y !== ve[got]) begin
                        failures++;
                        $display("[TB] FAIL b2b_order[%0d]: got y=%h expected %h", got, y, ve[got]);
                    end
                    got++;
                end
            end
        end
        checks++;
        if (got != 4) begin
            failures++;
            $display("[TB] FAIL b2b_count: got %0d results expected 4", got);
        end
        out_ready = 1'b1;
    endtask

    // Reset with a beat in stage 1 discards it; the next beat still takes
    // exactly two edges.
    task automatic test_reset_mid();
        @(negedge clk);
        a = 16'd7; b = 16'd7; c = 32'd1; lane_mask = 1'b0; op_signed = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== 32'd0 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid: got valid=%b y=%h in_ready=%b expected 0 00000000 0",
                     out_valid, y, in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_discard: got out_valid=%b expected 0", out_valid);
        end
        apply_stimulus(16'd2, 16'd3, 32'd4, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_latency: out_valid=%b after one edge, expected 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || y !== 32'd10) begin
            failures++;
            $display("[TB] FAIL reset_mid_first_beat: got valid=%b y=%h expected valid=1 y=0000000a", out_valid, y);
        end
    endtask

    // Scenario sequence.
    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        c         = '0;
        lane_mask = 1'b0;
        op_signed = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_mask();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
